// File: rtl/mux_arb_pkg.sv
// Shared types, constants and the round-robin search helper for the 8-way
// mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Scan downward so the lowest offset from ptr is written last and wins.
    function automatic rr_pick_t rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        rr_pick_t         res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// Existing 8-to-1 single-bit selector datapath shared by the arbiter.
module mux_8x1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_8x1_arbiter.sv
// Round-robin arbiter sequencing one mux_8x1 among eight requesters, with a
// bounded grant hold and back-to-back re-grant on release.
module mux_8x1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               dout
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;

    logic [SEL_W-1:0]   pick_ptr;
    rr_pick_t           pick;
    logic               release_grant;
    logic               mux_out;

    // On release the owner's successor leads the scan, putting the owner last.
    assign pick_ptr      = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
    assign pick          = rr_pick(req, pick_ptr);
    assign release_grant = !req[sel_q] || (hold_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << pick.idx;
                    sel_d   = pick.idx;
                    hold_d  = HOLD_W'(1);
                end
            end

            GRANT: begin
                if (!release_grant) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    ptr_d = pick_ptr;
                    if (pick.found) begin
                        gnt_d  = NUM_REQ'(1) << pick.idx;
                        sel_d  = pick.idx;
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    mux_8x1 u_mux (
        .in  (din),
        .sel (sel_q),
        .out (mux_out)
    );

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);
    assign dout = mux_out & busy;

endmodule
